// File: rtl/register_file.sv
// register_file
//   General-purpose register file: 2**ADDR_W registers of DATA_W bits,
//   one write port and two independent registered read ports.
//   Register 0 always reads as zero and ignores writes.
//   A read that hits the index being written in the same cycle returns the
//   new write data (write-through).
//
// Ports
//   clk        in   single clock, all state changes on its rising edge
//   reset_n    in   synchronous reset, ACTIVE HIGH (1 = reset) despite the name
//   wr_en      in   write enable
//   wr_index   in   write register index
//   wr_data    in   write data
//   rd_en1/2   in   read port enable
//   rd_index1/2 in  read port index
//   rd_data1/2 out  registered read data (one-cycle latency, holds when disabled)
//   rd_addr1/2 out  index that produced the current rd_data1/2
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_index,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_index1,
    input  logic              rd_en2,
    input  logic [ADDR_W-1:0] rd_index2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];

    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
    logic [ADDR_W-1:0] rd_addr2_q, rd_addr2_d;

    logic wr_live;
    assign wr_live = wr_en && (wr_index != '0);

    // Read value seen at the next edge: zero for index 0, write-through on a
    // same-index write, stored contents otherwise.
    function automatic logic [DATA_W-1:0] read_value(input logic [ADDR_W-1:0] idx);
        if (idx == '0)
            return '0;
        else if (wr_live && (wr_index == idx))
            return wr_data;
        else
            return regs_q[idx];
    endfunction

    always_comb begin
        rd_data1_d = rd_data1_q;
        rd_addr1_d = rd_addr1_q;
        if (rd_en1) begin
            rd_data1_d = read_value(rd_index1);
            rd_addr1_d = rd_index1;
        end
    end

    always_comb begin
        rd_data2_d = rd_data2_q;
        rd_addr2_d = rd_addr2_q;
        if (rd_en2) begin
            rd_data2_d = read_value(rd_index2);
            rd_addr2_d = rd_index2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs_q[i] <= '0;
            rd_data1_q <= '0;
            rd_data2_q <= '0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
        end else begin
            if (wr_live)
                regs_q[wr_index] <= wr_data;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            rd_addr1_q <= rd_addr1_d;
            rd_addr2_q <= rd_addr2_d;
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
    assign rd_addr1 = rd_addr1_q;
    assign rd_addr2 = rd_addr2_q;

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios plus random traffic.
// Stimulus pushes the expected post-edge outputs into a queue; a monitor
// pops one entry per edge and compares.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_en;
    logic [AW-1:0] wr_index;
    logic [DW-1:0] wr_data;
    logic          rd_en1;
    logic [AW-1:0] rd_index1;
    logic          rd_en2;
    logic [AW-1:0] rd_index2;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] rd_data2;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;

    always #5 clk = ~clk;

    register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .rd_en1    (rd_en1),
        .rd_index1 (rd_index1),
        .rd_en2    (rd_en2),
        .rd_index2 (rd_index2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2)
    );

    typedef struct {
        logic [DW-1:0] d1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d2;
        logic [AW-1:0] a2;
        string         tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: register contents and the visible output values.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] m_d1, m_d2;
    logic [AW-1:0] m_a1, m_a2;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // One clock cycle of stimulus; the model applies the write first and then
    // reads the resulting state, which gives write-through for free.
    task automatic cyc(input logic rst, input logic we, input logic [AW-1:0] wi,
                       input logic [DW-1:0] wd, input logic re1, input logic [AW-1:0] ri1,
                       input logic re2, input logic [AW-1:0] ri2, input string tag);
        logic [DW-1:0] nxt [N];
        exp_t e;
        @(negedge clk);
        reset_n   = rst;
        wr_en     = we;
        wr_index  = wi;
        wr_data   = wd;
        rd_en1    = re1;
        rd_index1 = ri1;
        rd_en2    = re2;
        rd_index2 = ri2;
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] = '0;
            m_d1 = '0; m_d2 = '0; m_a1 = '0; m_a2 = '0;
        end else begin
            nxt = mem;
            if (we && wi != 0) nxt[wi] = wd;
            if (re1) begin m_d1 = nxt[ri1]; m_a1 = ri1; end
            if (re2) begin m_d2 = nxt[ri2]; m_a2 = ri2; end
            mem = nxt;
        end
        e.d1 = m_d1; e.a1 = m_a1; e.d2 = m_d2; e.a2 = m_a2; e.tag = tag;
        sb.push_back(e);
    endtask

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, ".rd_data1"}, rd_data1, e.d1);
                chk({e.tag, ".rd_addr1"}, {27'd0, rd_addr1}, {27'd0, e.a1});
                chk({e.tag, ".rd_data2"}, rd_data2, e.d2);
                chk({e.tag, ".rd_addr2"}, {27'd0, rd_addr2}, {27'd0, e.a2});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1; wr_en = 1'b0; wr_index = '0; wr_data = '0;
        rd_en1 = 1'b0; rd_index1 = '0; rd_en2 = 1'b0; rd_index2 = '0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        m_d1 = '0; m_d2 = '0; m_a1 = '0; m_a2 = '0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");
        cyc(1, 1, 3, 32'hFFFF_FFFF, 1, 3, 1, 3, "reset_ignores_ops");

        for (int i = 0; i < N; i++)
            cyc(0, 1, AW'(i), DW'(i), 0, 0, 0, 0, "fill");
        for (int i = 0; i < N; i++)
            cyc(0, 0, 0, 0, 1, AW'(i), 1, AW'(i), "fill_read");

        cyc(0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, "x0_write");
        cyc(0, 0, 0, 0, 1, 0, 1, 0, "x0_read");

        cyc(0, 1, 7, 32'h1234_5678, 1, 7, 0, 0, "bypass");

        cyc(0, 0, 0, 0, 1, 5, 0, 0, "hold_read");
        cyc(0, 0, 0, 0, 0, 9, 0, 0, "hold1");
        cyc(0, 1, 5, 32'hAAAA_5555, 0, 9, 0, 0, "hold2");

        cyc(0, 0, 0, 0, 1, 3, 1, 30, "dual");
        cyc(0, 1, 30, 32'h0BAD_F00D, 1, 30, 1, 30, "dual_same_bypass");

        for (int k = 0; k < 600; k++) begin
            logic          r, we, re1, re2;
            logic [AW-1:0] wi, i1, i2;
            logic [DW-1:0] wd;
            r   = ($urandom_range(0, 49) == 0);
            we  = $urandom_range(0, 1);
            re1 = $urandom_range(0, 2) != 0;
            re2 = $urandom_range(0, 2) != 0;
            wi  = AW'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, N - 1));
            i1  = AW'($urandom_range(0, 3) == 0 ? wi : $urandom_range(0, N - 1));
            i2  = AW'($urandom_range(0, 3) == 0 ? i1 : $urandom_range(0, N - 1));
            wd  = $urandom;
            cyc(r, we, wi, wd, re1, i1, re2, i2, "random");
        end

        for (int i = 0; i < N; i++)
            cyc(0, 1, AW'(i), DW'(i), 1, AW'(i), 1, AW'(N - 1 - i), "refill");
        cyc(1, 1, 17, 32'h5A5A_5A5A, 1, 17, 1, 17, "midrun_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "after_reset");
        cyc(0, 0, 0, 0, 1, 17, 1, 17, "read17_after_reset");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", DW'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning index width; there are 2**ADDR_W registers.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, synchronous active-high reset: 1 = reset, sampled on rising clk only.
REQ-005 The block SHALL have port wr_en, input, 1, write enable.
REQ-006 The block SHALL have port wr_index, input, ADDR_W, write register index.
REQ-007 The block SHALL have port wr_data, input, DATA_W, write data.
REQ-008 The block SHALL have port rd_en1, input, 1, read port 1 enable.
REQ-009 The block SHALL have port rd_index1, input, ADDR_W, read port 1 index.
REQ-010 The block SHALL have port rd_en2, input, 1, read port 2 enable.
REQ-011 The block SHALL have port rd_index2, input, ADDR_W, read port 2 index.
REQ-012 The block SHALL have port rd_data1, output, DATA_W, registered read data, port 1.
REQ-013 The block SHALL have port rd_data2, output, DATA_W, registered read data, port 2.
REQ-014 The block SHALL have port rd_addr1, output, ADDR_W, index that produced the current rd_data1.
REQ-015 The block SHALL have port rd_addr2, output, ADDR_W, index that produced the current rd_data2.

Function
REQ-016 The storage SHALL be 2**ADDR_W registers of DATA_W bits, with one write port and two independent read ports.
REQ-017 Register 0 SHALL be hardwired to zero: writes to index 0 are discarded, and reads of index 0 return 0.
REQ-018 When wr_en=1 and reset is inactive at a rising edge, register[wr_index] SHALL take wr_data (index != 0).
REQ-019 When wr_en=0, no register SHALL change.
REQ-020 Each read port SHALL have one-cycle latency: when rd_enN=1 at edge k, rd_dataN holds register[rd_indexN] and rd_addrN holds rd_indexN after edge k.
REQ-021 When rd_enN=0 at an edge, rd_dataN and rd_addrN SHALL hold their previous values.
REQ-022 Write-through SHALL apply: if wr_en=1, wr_index=rd_indexN != 0 and rd_enN=1 in the same cycle, rd_dataN SHALL take wr_data, not the old contents.
REQ-023 Both read ports SHALL operate fully independently, including the case where both read the same index.
REQ-024 The read outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.
REQ-025 An out-of-range index cannot occur; all 2**ADDR_W indices SHALL be valid.

Reset
REQ-026 When reset_n=1 at a rising edge, all registers, rd_data1, rd_data2, rd_addr1 and rd_addr2 SHALL be cleared to 0; any writes or reads in that cycle are ignored.
REQ-027 Reset SHALL take priority over wr_en and rd_enN, including assertion mid-operation.
REQ-028 The first write or read SHALL take effect at the first rising edge where reset_n=0.

Verification
REQ-029 Fill-then-read: write data=i to index i for i=0..31 on consecutive cycles, then read both ports at index i=0..31 -> rd_data1=rd_data2=i and rd_addr=i one cycle later, except index 0, which returns 0.
REQ-030 x0 hardwire: write 0xDEADBEEF to index 0, then read index 0 -> rd_data=0x00000000 and rd_addr=0.
REQ-031 Bypass: in the same cycle, write 0x12345678 to index 7 and read index 7 on port 1 -> rd_data1=0x12345678 after that edge.
REQ-032 Hold: read index 5 (value 5), then drop rd_en1 and change rd_index1 to 9 -> rd_data1 stays 5 and rd_addr1 stays 5.
REQ-033 Dual-port: port 1 reads index 3 while port 2 reads index 30 in the same cycle -> rd_data1=3 and rd_data2=30.
REQ-034 Mid-run reset: assert reset_n=1 for one edge after filling, then read index 17 -> rd_data=0, and outputs are 0 immediately after the reset edge.
